// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// - md_op_e    : operation encodings presented on the 'operation' port
// - md_state_e : sequencer states (IDLE -> CALC -> FINISH -> IDLE)
// - is_signed_op() : true for the two operations that work on signed operands
`timescale 1ns/1ps
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } md_state_e;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_iter_step.sv
// One combinational iteration of the multiply/divide datapath.
// Ports:
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_in   : mul: {partial product, remaining multiplier bits}
//              div: low half holds the dividend bits still to shift in,
//                   which are progressively replaced by quotient bits
//   rem_in   : div partial remainder (WIDTH+1 bits); passed through for mul
//   operand  : mul multiplicand / div divisor (already made non-negative)
//   acc_out, rem_out : values after this iteration
`timescale 1ns/1ps
module mul_div_unit_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH:0]       rem_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_out,
    output logic [WIDTH:0]       rem_out
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shifted;
    logic [WIDTH:0] div_trial;

    // The multiply adds into the upper half with one extra bit so the carry
    // survives the right shift that follows.
    assign mul_sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
                       + (acc_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Bring the next dividend bit into the remainder, then try subtracting.
    // A set top bit of the trial means the divisor did not fit (borrow).
    assign div_shifted = {rem_in[WIDTH-1:0], acc_in[WIDTH-1]};
    assign div_trial   = div_shifted - {1'b0, operand};

    always_comb begin
        acc_out = acc_in;
        rem_out = rem_in;
        if (is_div) begin
            if (div_trial[WIDTH]) begin
                rem_out = div_shifted;
                acc_out = {{WIDTH{1'b0}}, acc_in[WIDTH-2:0], 1'b0};
            end else begin
                rem_out = div_trial;
                acc_out = {{WIDTH{1'b0}}, acc_in[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_out = {mul_sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, rst_n         : rising-edge clock, asynchronous active-low reset
//   start, operation   : issue strobe and md_op_e code, sampled only in IDLE
//   inputA, inputB     : rs / rt operands
//   cancel             : pipeline flush, aborts any in-flight operation
//   busy               : high while CALC or FINISH
//   done               : one-cycle pulse once hi/lo hold a new result
//   hi, lo             : architectural HI/LO registers
// Signed operations run on magnitudes; signs are re-applied in FINISH.
`timescale 1ns/1ps
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        operation,
    input  logic [WIDTH-1:0]  inputA,
    input  logic [WIDTH-1:0]  inputB,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_e           state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH:0]      rem_q, rem_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic                is_div_q, is_div_d;
    logic                neg_q, neg_d;
    logic                a_neg_q, a_neg_d;
    logic                b_zero_q, b_zero_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic                done_q, done_d;

    logic                a_neg, b_neg;
    logic [WIDTH-1:0]    abs_a, abs_b;
    logic [2*WIDTH-1:0]  step_acc;
    logic [WIDTH:0]      step_rem;
    logic [2*WIDTH-1:0]  prod_res;
    logic [WIDTH-1:0]    quo_res, rem_res;

    assign a_neg = is_signed_op(operation) & inputA[WIDTH-1];
    assign b_neg = is_signed_op(operation) & inputB[WIDTH-1];
    assign abs_a = a_neg ? (~inputA + 1'b1) : inputA;
    assign abs_b = b_neg ? (~inputB + 1'b1) : inputB;

    mul_div_unit_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc_in  (acc_q),
        .rem_in  (rem_q),
        .operand (opnd_q),
        .acc_out (step_acc),
        .rem_out (step_rem)
    );

    // Sign fix-up. A zero divisor forces an all-ones quotient; the remainder
    // path already ends up holding the original dividend in that case.
    assign prod_res = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_res  = b_zero_q ? {WIDTH{1'b1}}
                    : (neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]);
    assign rem_res  = a_neg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        b_zero_d = b_zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // cancel wins over anything issued in the same cycle
                if (start && !cancel) begin
                    case (operation)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            state_d  = ST_CALC;
                            count_d  = '0;
                            is_div_d = (operation == MD_DIV) || (operation == MD_DIVU);
                            neg_d    = a_neg ^ b_neg;
                            a_neg_d  = a_neg;
                            b_zero_d = (inputB == '0);
                            rem_d    = '0;
                            if ((operation == MD_DIV) || (operation == MD_DIVU)) begin
                                opnd_d = abs_b;
                                acc_d  = {{WIDTH{1'b0}}, abs_a};
                            end else begin
                                opnd_d = abs_a;
                                acc_d  = {{WIDTH{1'b0}}, abs_b};
                            end
                        end
                        MD_MTHI: hi_d = inputA;
                        MD_MTLO: lo_d = inputA;
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = step_acc;
                    rem_d   = step_rem;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(WIDTH-1)) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        hi_d = prod_res[2*WIDTH-1:WIDTH];
                        lo_d = prod_res[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            b_zero_q <= b_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
